// File: rtl/star_row_mapper_pkg.sv
// Shared geometry defaults and FSM state encoding for the star row mapper.
package star_row_mapper_pkg;

  localparam int DEF_XSZ       = 3;
  localparam int DEF_YSZ       = 3;
  localparam int DEF_ADDRSZ    = 6;
  localparam int DEF_COLSZ     = 3;
  localparam int DEF_IMG_W     = 6;
  localparam int DEF_IMG_H     = 6;
  localparam int DEF_THRESHOLD = 0;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_SEED_REQ  = 4'd1,
    S_SEED_WAIT = 4'd2,
    S_UP_REQ    = 4'd3,
    S_UP_WAIT   = 4'd4,
    S_DN_REQ    = 4'd5,
    S_DN_WAIT   = 4'd6,
    S_DONE      = 4'd7
  } state_e;

endpackage

// File: rtl/star_row_mapper_address_translator.sv
// Raster address of pixel (x, y): y*IMG_W + x, zero-extended to ADDRSZ.
module address_translator import star_row_mapper_pkg::*; #(
  parameter int XSZ    = DEF_XSZ,
  parameter int YSZ    = DEF_YSZ,
  parameter int ADDRSZ = DEF_ADDRSZ,
  parameter int IMG_W  = DEF_IMG_W
) (
  input  logic [XSZ-1:0]    x_i,
  input  logic [YSZ-1:0]    y_i,
  output logic [ADDRSZ-1:0] mem_address_o
);

  localparam logic [ADDRSZ-1:0] IMG_W_A = ADDRSZ'(IMG_W);

  assign mem_address_o = ADDRSZ'(y_i) * IMG_W_A + ADDRSZ'(x_i);

endmodule

// File: rtl/star_row_mapper.sv
// Walks column xSeed up then down from the seed row and reports the star's
// vertical extent; one memory read (REQ + WAIT) per visited row.
module star_row_mapper import star_row_mapper_pkg::*; #(
  parameter int XSZ       = DEF_XSZ,
  parameter int YSZ       = DEF_YSZ,
  parameter int ADDRSZ    = DEF_ADDRSZ,
  parameter int COLSZ     = DEF_COLSZ,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int THRESHOLD = DEF_THRESHOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              goMapRows,
  input  logic [XSZ-1:0]    xSeed,
  input  logic [YSZ-1:0]    ySeed,
  input  logic [COLSZ-1:0]  pixVal,
  output logic              rdEn,
  output logic [ADDRSZ-1:0] rdAddr,
  output logic              busy,
  output logic [YSZ-1:0]    yTop,
  output logic [YSZ-1:0]    yBottom,
  output logic              seedDark,
  output logic              topBottomFound
);

  localparam logic [YSZ-1:0]   YMAX = YSZ'(IMG_H - 1);
  localparam logic [COLSZ-1:0] THR  = COLSZ'(THRESHOLD);

  state_e           state_q, state_d;
  logic [XSZ-1:0]   xseed_q, xseed_d;
  logic [YSZ-1:0]   row_q, row_d;
  logic [YSZ-1:0]   ytop_q, ytop_d;
  logic [YSZ-1:0]   ybot_q, ybot_d;
  logic             dark_q, dark_d;
  logic             bright;
  logic             down;
  logic [YSZ-1:0]   down_from;

  assign bright = pixVal > THR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      xseed_q <= '0;
      row_q   <= '0;
      ytop_q  <= '0;
      ybot_q  <= '0;
      dark_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xseed_q <= xseed_d;
      row_q   <= row_d;
      ytop_q  <= ytop_d;
      ybot_q  <= ybot_d;
      dark_q  <= dark_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    xseed_d   = xseed_q;
    row_d     = row_q;
    ytop_d    = ytop_q;
    ybot_d    = ybot_q;
    dark_d    = dark_q;
    down      = 1'b0;
    down_from = ybot_q;
    case (state_q)
      S_IDLE: begin
        if (goMapRows) begin
          xseed_d = xSeed;
          row_d   = ySeed;
          dark_d  = 1'b0;
          state_d = S_SEED_REQ;
        end
      end
      S_SEED_REQ: state_d = S_SEED_WAIT;
      S_SEED_WAIT: begin
        // row_q still holds ySeed here; yBottom is being written this cycle,
        // so the down phase must start from row_q rather than ybot_q.
        ytop_d = row_q;
        ybot_d = row_q;
        if (!bright) begin
          dark_d  = 1'b1;
          state_d = S_DONE;
        end else if (row_q == '0) begin
          down      = 1'b1;
          down_from = row_q;
        end else begin
          row_d   = row_q - 1'b1;
          state_d = S_UP_REQ;
        end
      end
      S_UP_REQ: state_d = S_UP_WAIT;
      S_UP_WAIT: begin
        if (bright) begin
          ytop_d = row_q;
          if (row_q == '0) begin
            down = 1'b1;
          end else begin
            row_d   = row_q - 1'b1;
            state_d = S_UP_REQ;
          end
        end else begin
          down = 1'b1;
        end
      end
      S_DN_REQ: state_d = S_DN_WAIT;
      S_DN_WAIT: begin
        if (bright) begin
          ybot_d = row_q;
          if (row_q == YMAX) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_DN_REQ;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Entering the down phase never costs a cycle: it resolves straight from a WAIT state.
    if (down) begin
      if (down_from == YMAX) begin
        state_d = S_DONE;
      end else begin
        row_d   = down_from + 1'b1;
        state_d = S_DN_REQ;
      end
    end
  end

  address_translator #(
    .XSZ    (XSZ),
    .YSZ    (YSZ),
    .ADDRSZ (ADDRSZ),
    .IMG_W  (IMG_W)
  ) u_addr (
    .x_i           (xseed_q),
    .y_i           (row_q),
    .mem_address_o (rdAddr)
  );

  assign rdEn           = (state_q == S_SEED_REQ) || (state_q == S_UP_REQ) || (state_q == S_DN_REQ);
  assign busy           = (state_q != S_IDLE);
  assign topBottomFound = (state_q == S_DONE);
  assign yTop           = ytop_q;
  assign yBottom        = ybot_q;
  assign seedDark       = dark_q;

endmodule

// File: tb/tb_star_row_mapper.sv
// Bench for star_row_mapper: 6x6 image RAM model, column-walk reference model
// checked every cycle, plus per-scenario hand-computed expectations.
module tb_star_row_mapper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic [2:0] xs = '0;
  logic [2:0] ys = '0;
  logic [2:0] pix = '0;
  logic       rdEn, busy, dark, found;
  logic [5:0] rdAddr;
  logic [2:0] yTop, yBot;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [2:0] mem [36];

  always #5 clk = ~clk;

  star_row_mapper dut (
    .clk            (clk),
    .reset          (reset),
    .goMapRows      (go),
    .xSeed          (xs),
    .ySeed          (ys),
    .pixVal         (pix),
    .rdEn           (rdEn),
    .rdAddr         (rdAddr),
    .busy           (busy),
    .yTop           (yTop),
    .yBottom        (yBot),
    .seedDark       (dark),
    .topBottomFound (found)
  );

  always @(posedge clk) if (rdEn) pix <= mem[rdAddr];

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: list the rows visited, scanning outward until a dark pixel or the edge.
  function automatic void predict(input int x, input int y, output int r, output int top,
                                  output int bot, output int dk, output int a[16]);
    for (int i = 0; i < 16; i++) a[i] = 0;
    a[0] = y * 6 + x;
    r    = 1;
    top  = y;
    bot  = y;
    dk   = 0;
    if (mem[y * 6 + x] == 0) begin
      dk = 1;
      return;
    end
    while (top > 0) begin
      a[r] = (top - 1) * 6 + x;
      r++;
      if (mem[(top - 1) * 6 + x] > 0) top--;
      else break;
    end
    while (bot < 5) begin
      a[r] = (bot + 1) * 6 + x;
      r++;
      if (mem[(bot + 1) * 6 + x] > 0) bot++;
      else break;
    end
  endfunction

  logic m_idle;
  int   m_n, m_R, m_top, m_bot, m_dark;
  int   m_addr [16];
  int   h_top, h_bot, h_dark;

  always @(posedge clk or posedge reset) begin : model
    int r, t, b, d;
    int a [16];
    if (reset) begin
      m_idle <= 1'b1;
      m_n    <= 0;
      h_top  <= 0;
      h_bot  <= 0;
      h_dark <= 0;
    end else if (m_idle) begin
      if (go) begin
        predict(int'(xs), int'(ys), r, t, b, d, a);
        m_R    <= r;
        m_top  <= t;
        m_bot  <= b;
        m_dark <= d;
        m_addr <= a;
        m_n    <= 1;
        m_idle <= 1'b0;
        h_dark <= 0;
      end
    end else if (m_n == 1 + 2 * m_R) begin
      m_idle <= 1'b1;
      h_top  <= m_top;
      h_bot  <= m_bot;
      h_dark <= m_dark;
    end else begin
      m_n <= m_n + 1;
    end
  end

  always @(negedge clk) begin : compare
    logic exp_rd;
    if (reset) begin
      chk("reset_outputs", int'({busy, rdEn, found, yTop, yBot, dark, rdAddr}), 0);
    end else if (m_idle) begin
      chk("idle_busy", int'(busy), 0);
      chk("idle_rdEn", int'(rdEn), 0);
      chk("idle_found", int'(found), 0);
      chk("held_yTop", int'(yTop), h_top);
      chk("held_yBottom", int'(yBot), h_bot);
      chk("held_seedDark", int'(dark), h_dark);
    end else begin
      exp_rd = (m_n % 2 == 1) && (m_n < 1 + 2 * m_R);
      chk("op_busy", int'(busy), 1);
      chk("op_rdEn", int'(rdEn), int'(exp_rd));
      if (exp_rd) chk("op_rdAddr", int'(rdAddr), m_addr[(m_n - 1) / 2]);
      chk("op_found", int'(found), int'(m_n == 1 + 2 * m_R));
      if (m_n == 1 + 2 * m_R) begin
        chk("done_yTop", int'(yTop), m_top);
        chk("done_yBottom", int'(yBot), m_bot);
        chk("done_seedDark", int'(dark), m_dark);
      end
    end
  end

  task automatic img_clear();
    for (int i = 0; i < 36; i++) mem[i] = '0;
  endtask

  task automatic px(input int x, input int y, input int v);
    mem[y * 6 + x] = 3'(v);
  endtask

  task automatic img_star1();
    img_clear();
    px(2, 1, 7); px(2, 2, 1); px(2, 3, 3); px(2, 4, 5);
    px(3, 0, 2); px(1, 5, 4); px(3, 3, 6);
  endtask

  // One operation with literal expectations; dup>0 injects a stray go at that cycle.
  task automatic run(input string nm, input int x, input int y, input int dup,
                     input int et, input int eb, input int ed, input int ef, input int er);
    int fcyc, nfound, nrd;
    fcyc = -1; nfound = 0; nrd = 0;
    @(posedge clk); #1;
    go = 1'b1; xs = 3'(x); ys = 3'(y);
    @(posedge clk); #1;
    go = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == dup) begin
        go = 1'b1; xs = 3'd4; ys = 3'd2;
      end
      @(negedge clk);
      if (rdEn) nrd++;
      if (found) begin
        nfound++;
        if (fcyc < 0) fcyc = n;
      end
      @(posedge clk); #1;
      go = 1'b0; xs = 3'(x); ys = 3'(y);
      if (fcyc >= 0 && n >= fcyc + 2) break;
    end
    chk({nm, "_found_cycle"}, fcyc, ef);
    chk({nm, "_reads"}, nrd, er);
    chk({nm, "_pulses"}, nfound, 1);
    chk({nm, "_yTop"}, int'(yTop), et);
    chk({nm, "_yBottom"}, int'(yBot), eb);
    chk({nm, "_seedDark"}, int'(dark), ed);
  endtask

  initial begin
    int nf;
    img_clear();
    #12;
    chk("por_outputs", int'({busy, rdEn, found, yTop, yBot, dark, rdAddr}), 0);
    @(negedge clk);
    reset = 1'b0;

    img_star1();
    run("s1", 2, 3, 0, 1, 4, 0, 13, 6);
    run("s5_dup_go", 2, 3, 5, 1, 4, 0, 13, 6);

    img_clear();
    for (int r = 0; r < 6; r++) px(0, r, r + 1);
    px(1, 2, 3);
    run("s2_full_col", 0, 0, 0, 0, 5, 0, 13, 6);

    img_clear();
    px(4, 1, 5); px(4, 3, 5); px(3, 2, 7);
    run("s3_dark_seed", 4, 2, 0, 2, 2, 1, 3, 1);

    img_clear();
    px(5, 5, 1); px(4, 5, 2);
    run("s4_corner", 5, 5, 0, 5, 5, 0, 5, 2);

    // Abort scenario 1 in UP_WAIT (cycle 4) with an off-edge reset.
    img_star1();
    @(posedge clk); #1;
    go = 1'b1; xs = 3'd2; ys = 3'd3;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_abort_busy", int'(busy), 1);
    chk("pre_abort_rdEn", int'(rdEn), 0);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", int'({busy, rdEn, found, yTop, yBot, dark, rdAddr}), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    nf = 0;
    repeat (12) begin
      @(negedge clk);
      if (found) nf++;
    end
    chk("abort_no_found", nf, 0);
    run("s6_after_abort", 2, 3, 0, 1, 4, 0, 13, 6);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
